// File: rtl/sr_latch_bank_sched_if.sv
// Requester-side handshake bundle for the SR latch bank scheduler.
// Requesters use the master modport and the scheduler uses the slave modport.
interface sr_latch_bank_sched_if #(
  parameter int NREQ  = 4,
  parameter int IDX_W = 3
);
  logic [NREQ-1:0]       req;
  logic [2*NREQ-1:0]     op;
  logic [IDX_W*NREQ-1:0] idx;
  logic [NREQ-1:0]       gnt;
  logic                  ack;
  logic                  err;
  logic                  busy;

  modport master (output req, op, idx, input gnt, ack, err, busy);
  modport slave  (input req, op, idx, output gnt, ack, err, busy);
endinterface

// File: rtl/sr_latch_bank_sched.sv
// Round-robin scheduler that turns granted set/reset/clear ops into timed S/R/En/clear
// pulse sequences on a shared SR latch bank, and keeps a shadow copy of the cell states.
module sr_latch_bank_sched #(
  parameter int NREQ      = 4,
  parameter int NLATCH    = 8,
  parameter int IDX_W     = 3,
  parameter int PULSE_CYC = 2,
  parameter int CLR_CYC   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sr_latch_bank_sched_if.slave  bus,
  output logic [NLATCH-1:0]     lat_s,
  output logic [NLATCH-1:0]     lat_r,
  output logic [NLATCH-1:0]     lat_en,
  output logic                  lat_clear,
  output logic [NLATCH-1:0]     shadow_q
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARB   = 3'd1;
  localparam logic [2:0] S_SETUP = 3'd2;
  localparam logic [2:0] S_PULSE = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;
  localparam logic [2:0] S_CLR   = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_RST = 2'b01;
  localparam logic [1:0] OP_SET = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;

  logic [2:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [1:0]        op_q, op_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              rej_q, rej_d;
  logic [NLATCH-1:0] shadow_d;

  logic              found;
  logic [PW-1:0]     win;
  logic [1:0]        sel_op;
  logic [IDX_W-1:0]  sel_idx;
  logic              sel_rej;
  logic [NLATCH-1:0] cell_oh;
  logic              drive_sr;

  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] a, input int unsigned b);
    int unsigned s;
    s = (32'(a) + b) % NREQ;
    return PW'(s);
  endfunction

  // Search starts at the RR pointer so the last winner has lowest priority next time.
  always_comb begin
    found   = 1'b0;
    win     = '0;
    sel_op  = OP_NOP;
    sel_idx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!found && bus.req[wrap_add(ptr_q, i)]) begin
        found = 1'b1;
        win   = wrap_add(ptr_q, i);
      end
    end
    for (int unsigned r = 0; r < NREQ; r++) begin
      if (win == PW'(r)) begin
        sel_op  = bus.op[2*r +: 2];
        sel_idx = bus.idx[IDX_W*r +: IDX_W];
      end
    end
    sel_rej = (sel_op == OP_NOP) || (32'(sel_idx) >= 32'(NLATCH));
  end

  always_comb begin
    cell_oh = '0;
    for (int unsigned i = 0; i < NLATCH; i++) begin
      cell_oh[i] = (32'(idx_q) == i);
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    op_d     = op_q;
    idx_d    = idx_q;
    rej_d    = rej_q;
    shadow_d = shadow_q;
    case (state_q)
      S_IDLE: if (|bus.req) state_d = S_ARB;
      S_ARB: begin
        cnt_d = '0;
        if (found) begin
          gnt_d      = '0;
          gnt_d[win] = 1'b1;
          ptr_d      = wrap_add(win, 1);
          op_d       = sel_op;
          idx_d      = sel_idx;
          rej_d      = sel_rej;
          if (sel_rej)               state_d = S_DONE;
          else if (sel_op == OP_CLR) state_d = S_CLR;
          else                       state_d = S_SETUP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETUP: begin
        cnt_d   = '0;
        state_d = S_PULSE;
      end
      S_PULSE: begin
        if (cnt_q == 4'(PULSE_CYC - 1)) state_d = S_HOLD;
        else                            cnt_d   = cnt_q + 4'd1;
      end
      S_HOLD: begin
        for (int unsigned i = 0; i < NLATCH; i++) begin
          if (cell_oh[i]) shadow_d[i] = (op_q == OP_SET);
        end
        state_d = S_DONE;
      end
      S_CLR: begin
        if (cnt_q == 4'(CLR_CYC - 1)) begin
          shadow_d = '0;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_DONE: begin
        gnt_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      ptr_q    <= '0;
      gnt_q    <= '0;
      op_q     <= OP_NOP;
      idx_q    <= '0;
      rej_q    <= 1'b0;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      op_q     <= op_d;
      idx_q    <= idx_d;
      rej_q    <= rej_d;
      shadow_q <= shadow_d;
    end
  end

  // Bank pins decode straight from registered state, so a reset edge drops them at once.
  assign drive_sr  = (state_q == S_SETUP) || (state_q == S_PULSE) || (state_q == S_HOLD);
  assign lat_s     = (drive_sr && op_q == OP_SET) ? cell_oh : '0;
  assign lat_r     = (drive_sr && op_q == OP_RST) ? cell_oh : '0;
  assign lat_en    = (state_q == S_PULSE) ? cell_oh : '0;
  assign lat_clear = (state_q == S_CLR);

  assign bus.gnt  = gnt_q;
  assign bus.ack  = (state_q == S_DONE);
  assign bus.err  = (state_q == S_DONE) && rej_q;
  assign bus.busy = (state_q != S_IDLE);
endmodule

// File: tb/tb_sr_latch_bank_sched.sv
// Directed bench for sr_latch_bank_sched: reset, set/reset/clear sequences, error ops,
// reset mid-pulse and round-robin ordering, with hand-computed expectations.
module tb_sr_latch_bank_sched;
  localparam int NREQ = 4;
  localparam int NLATCH = 8;
  localparam int IDX_W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NLATCH-1:0] lat_s, lat_r, lat_en, shadow_q;
  logic lat_clear;

  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned viol = 0;
  int unsigned cyc_cnt = 0;
  logic mon_on = 1'b0;

  sr_latch_bank_sched_if #(.NREQ(NREQ), .IDX_W(IDX_W)) bus ();

  sr_latch_bank_sched #(
    .NREQ(NREQ), .NLATCH(NLATCH), .IDX_W(IDX_W), .PULSE_CYC(2), .CLR_CYC(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .lat_s(lat_s), .lat_r(lat_r), .lat_en(lat_en), .lat_clear(lat_clear), .shadow_q(shadow_q)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  always @(negedge clk) begin
    if (mon_on) begin
      if ((lat_s & lat_r) !== '0) viol++;
      if (lat_clear === 1'b1 && {lat_s, lat_r, lat_en} !== '0) viol++;
      if ($countones(lat_en) > 1) viol++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one op on requester r and waits (bounded) for its ack; cycle 1 is the drive cycle.
  task automatic run_op(input int unsigned r, input logic [1:0] o, input logic [3:0] ix,
                        output int unsigned lat, output logic e, output logic [3:0] g,
                        output int unsigned ns, output int unsigned nr, output int unsigned nen,
                        output int unsigned nclr, output int unsigned enpos, output logic pins);
    int unsigned cyc, first_sr, first_en;
    bus.op[r*2 +: 2] = o;
    bus.idx[r*4 +: 4] = ix;
    bus.req[r] = 1'b1;
    lat = 0; e = 1'b0; g = '0; ns = 0; nr = 0; nen = 0; nclr = 0; enpos = 0; pins = 1'b0;
    cyc = 1; first_sr = 0; first_en = 0;
    for (int unsigned n = 0; n < 40; n++) begin
      tick();
      cyc++;
      if (ix < 4'd8) begin
        if (lat_s[ix[2:0]]) ns++;
        if (lat_r[ix[2:0]]) nr++;
        if ((lat_s[ix[2:0]] || lat_r[ix[2:0]]) && first_sr == 0) first_sr = cyc;
        if (lat_en[ix[2:0]]) begin
          nen++;
          if (first_en == 0) first_en = cyc;
        end
      end
      if (lat_clear) nclr++;
      if ({lat_s, lat_r, lat_en, lat_clear} != '0) pins = 1'b1;
      if (bus.ack) begin
        lat = cyc;
        e = bus.err;
        g = bus.gnt;
        break;
      end
    end
    bus.req[r] = 1'b0;
    if (first_sr != 0 && first_en != 0) enpos = first_en - first_sr + 1;
    tick();
  endtask

  int unsigned lat, ns, nr, nen, nclr, enpos, t0, prev;
  logic e, pins, seen, got;
  logic [3:0] g;
  logic [3:0] rr_exp [5];

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req = '0;
    bus.op = '0;
    bus.idx = '0;

    // Reset held with every requester active
    rst_n = 1'b0;
    bus.req = 4'hF;
    bus.op = 8'hAA;
    repeat (3) tick();
    check("rst_gnt", bus.gnt, 0);
    check("rst_ctl", {bus.ack, bus.err, bus.busy}, 0);
    check("rst_pins", {lat_s, lat_r, lat_en, lat_clear}, 0);
    check("rst_shadow", shadow_q, 0);
    bus.req = '0;
    rst_n = 1'b1;
    tick();
    mon_on = 1'b1;

    // Single set of cell 5
    run_op(0, 2'b10, 4'd5, lat, e, g, ns, nr, nen, nclr, enpos, pins);
    check("set5_lat", lat, 7);
    check("set5_err", e, 0);
    check("set5_gnt", g, 4'b0001);
    check("set5_s_cycles", ns, 4);
    check("set5_en_cycles", nen, 2);
    check("set5_en_pos", enpos, 2);
    check("set5_r_cycles", nr, 0);
    check("set5_shadow", shadow_q, 8'h20);

    run_op(1, 2'b10, 4'd0, lat, e, g, ns, nr, nen, nclr, enpos, pins);
    check("set0_shadow", shadow_q, 8'h21);
    check("set0_gnt", g, 4'b0010);
    run_op(2, 2'b10, 4'd2, lat, e, g, ns, nr, nen, nclr, enpos, pins);
    check("set2_shadow", shadow_q, 8'h25);
    run_op(3, 2'b10, 4'd1, lat, e, g, ns, nr, nen, nclr, enpos, pins);
    check("set1_shadow", shadow_q, 8'h27);

    // Reset op on cell 1
    run_op(0, 2'b01, 4'd1, lat, e, g, ns, nr, nen, nclr, enpos, pins);
    check("rst1_lat", lat, 7);
    check("rst1_r_cycles", nr, 4);
    check("rst1_s_cycles", ns, 0);
    check("rst1_en_cycles", nen, 2);
    check("rst1_shadow", shadow_q, 8'h25);
    run_op(1, 2'b10, 4'd7, lat, e, g, ns, nr, nen, nclr, enpos, pins);
    check("set7_shadow", shadow_q, 8'hA5);

    // Rejected ops: nop and out-of-range index
    run_op(3, 2'b00, 4'd3, lat, e, g, ns, nr, nen, nclr, enpos, pins);
    check("nop_lat", lat, 3);
    check("nop_err", e, 1);
    check("nop_pins", pins, 0);
    check("nop_shadow", shadow_q, 8'hA5);
    run_op(0, 2'b10, 4'd9, lat, e, g, ns, nr, nen, nclr, enpos, pins);
    check("idx9_lat", lat, 3);
    check("idx9_err", e, 1);
    check("idx9_gnt", g, 4'b0001);
    check("idx9_pins", pins, 0);
    check("idx9_shadow", shadow_q, 8'hA5);

    // Bank clear
    run_op(2, 2'b11, 4'd0, lat, e, g, ns, nr, nen, nclr, enpos, pins);
    check("clr_lat", lat, 5);
    check("clr_err", e, 0);
    check("clr_cycles", nclr, 2);
    check("clr_en", nen, 0);
    check("clr_shadow", shadow_q, 0);

    // Reset in the middle of a pulse
    run_op(0, 2'b10, 4'd6, lat, e, g, ns, nr, nen, nclr, enpos, pins);
    check("set6_shadow", shadow_q, 8'h40);
    bus.op[3:2] = 2'b10;
    bus.idx[7:4] = 4'd3;
    bus.req[1] = 1'b1;
    seen = 1'b0;
    for (int unsigned n = 0; n < 20; n++) begin
      tick();
      if (lat_en[3]) begin
        seen = 1'b1;
        break;
      end
    end
    check("midp_en_seen", seen, 1);
    rst_n = 1'b0;
    bus.req = '0;
    tick();
    check("midp_pins", {lat_s, lat_r, lat_en, lat_clear}, 0);
    check("midp_ack", bus.ack, 0);
    check("midp_gnt", bus.gnt, 0);
    check("midp_shadow", shadow_q, 0);
    rst_n = 1'b1;
    tick();
    run_op(2, 2'b10, 4'd3, lat, e, g, ns, nr, nen, nclr, enpos, pins);
    check("post_rst_lat", lat, 7);
    check("post_rst_shadow", shadow_q, 8'h08);

    // Round-robin with all requesters held; pointer reset to 0 first
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    bus.op = 8'hAA;
    bus.idx = {4'd4, 4'd3, 4'd2, 4'd1};
    rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
    rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;
    bus.req = 4'hF;
    t0 = cyc_cnt;
    prev = 0;
    for (int unsigned k = 0; k < 5; k++) begin
      got = 1'b0;
      for (int unsigned n = 0; n < 40; n++) begin
        tick();
        if (bus.ack) begin
          got = 1'b1;
          break;
        end
      end
      check($sformatf("rr_ack%0d", k), got, 1);
      check($sformatf("rr_gnt%0d", k), bus.gnt, rr_exp[k]);
      if (k == 0) check("rr_first_lat", cyc_cnt - t0 + 1, 7);
      else        check($sformatf("rr_space%0d", k), cyc_cnt - prev, 7);
      prev = cyc_cnt;
    end
    bus.req = '0;
    tick();
    tick();
    check("rr_shadow", shadow_q, 8'h1E);
    check("rr_idle", bus.busy, 0);

    check("invariants", viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
